// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: sequences the log2(N) radix-2 stages of an in-place FFT.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   start, abort     - begin a full pass / cancel the pass in progress
//   addrGenDone      - address generator has issued every butterfly of the stage
//   run              - run level to the address generator (high only in RUN)
//   stageCount       - current stage index
//   bankSel          - ping-pong bank read in the current stage
//   busy, done, err  - not idle / one-cycle pass-complete pulse / sticky stage timeout
module fft_stage_sequencer #(
    parameter int FFT_N          = 10,
    parameter int STAGE_COUNT_BW = 4,
    parameter int PIPE_LATENCY   = 4,
    parameter int TIMEOUT_MARGIN = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      addrGenDone,
    output logic                      run,
    output logic [STAGE_COUNT_BW-1:0] stageCount,
    output logic                      bankSel,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int CW    = FFT_N + 1;
    localparam int LIMIT = 2 ** (FFT_N - 1) + 1 + TIMEOUT_MARGIN;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cyc_q, cyc_d;
    logic [3:0]                drn_q, drn_d;
    logic [STAGE_COUNT_BW-1:0] stage_q, stage_d;
    logic                      bank_q, bank_d;
    logic                      err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            drn_q   <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            drn_q   <= drn_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        drn_d   = drn_q;
        stage_d = stage_q;
        bank_d  = bank_q;
        err_d   = err_q;
        // abort outranks every other exit; stage/bank/err keep their values
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cyc_d   = '0;
                        stage_d = '0;
                        bank_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                RUN: begin
                    cyc_d = cyc_q + 1'b1;
                    if (addrGenDone) begin
                        state_d = DRAIN;
                        drn_d   = '0;
                    end else if (cyc_d == CW'(LIMIT)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                DRAIN: begin
                    drn_d = drn_q + 1'b1;
                    if (drn_q == 4'(PIPE_LATENCY - 1)) begin
                        if (stage_q == STAGE_COUNT_BW'(FFT_N - 1)) begin
                            state_d = FINISH;
                        end else begin
                            state_d = RUN;
                            cyc_d   = '0;
                            stage_d = stage_q + 1'b1;
                            bank_d  = ~bank_q;
                        end
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign run        = state_q == RUN;
    assign busy       = state_q != IDLE;
    assign done       = state_q == FINISH;
    assign stageCount = stage_q;
    assign bankSel    = bank_q;
    assign err        = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed scenarios checked against a timeline model and literal expectations.
module tb_fft_stage_sequencer;
    localparam int FN    = 4;
    localparam int PL    = 4;
    localparam int TM    = 8;
    localparam int RL    = 2 ** (FN - 1) + 1;
    localparam int SL    = RL + PL;
    localparam int LASTT = FN * SL;
    localparam int TO    = RL + TM;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       addrGenDone;
    logic       run;
    logic [3:0] stageCount;
    logic       bankSel;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cur_id = 0;
    int cur_c  = 0;

    bit ag_stuck = 1'b0;
    bit ag_force = 1'b0;
    int ag_cnt   = 0;

    bit mvalid = 1'b0;
    bit m_act  = 1'b0;
    bit m_err  = 1'b0;
    int m_t    = 0;
    int m_stage = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .FFT_N(FN),
        .STAGE_COUNT_BW(4),
        .PIPE_LATENCY(PL),
        .TIMEOUT_MARGIN(TM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .addrGenDone(addrGenDone),
        .run(run),
        .stageCount(stageCount),
        .bankSel(bankSel),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // address generator: done in its RL-th consecutive run cycle, optionally forced high while draining
    always @(posedge clk) ag_cnt <= (run === 1'b1) ? ag_cnt + 1 : 0;
    assign addrGenDone = !ag_stuck && ((run && ag_cnt == RL - 1) || (ag_force && busy && !run));

    function automatic int cur_stage(input int t);
        return (t >= LASTT) ? FN - 1 : t / SL;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s scn %0d cycle %0d got %0d want %0d", nm, cur_id, cur_c, act, exp);
        end
    endtask

    // timeline model: a pass is m_t cycles old; stages are SL cycles, RUN is the first RL of them
    always @(posedge clk) begin
        if (reset) begin
            mvalid = 1'b1;
            m_act = 1'b0; m_t = 0; m_err = 1'b0; m_stage = 0;
        end else if (mvalid) begin
            if (!m_act) begin
                if (start) begin
                    m_act = 1'b1; m_t = 0; m_err = 1'b0; m_stage = 0;
                end
            end else if (abort || (!ag_stuck && m_t == LASTT)) begin
                m_act = 1'b0;
                m_stage = ag_stuck ? 0 : cur_stage(m_t);
            end else if (ag_stuck && m_t == TO - 1) begin
                m_act = 1'b0; m_err = 1'b1;
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            bit e_run, e_busy, e_done;
            int e_stage;
            if (!m_act) begin
                e_run = 0; e_busy = 0; e_done = 0; e_stage = m_stage;
            end else if (ag_stuck) begin
                e_run = 1; e_busy = 1; e_done = 0; e_stage = 0;
            end else begin
                e_busy = 1;
                e_done = m_t == LASTT;
                e_stage = cur_stage(m_t);
                e_run = !e_done && (m_t % SL) < RL;
            end
            chk("m_run", run, e_run);
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_stage", stageCount, e_stage);
            chk("m_bank", bankSel, e_stage % 2);
            chk("m_err", err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input int id, input int c);
        case (id)
            1: begin
                if (c == 1)  begin chk("run_c1", run, 1); chk("stage_c1", stageCount, 0); chk("bank_c1", bankSel, 0); end
                if (c == 9)  chk("run_c9", run, 1);
                if (c == 10) chk("run_c10", run, 0);
                if (c == 13) chk("run_c13", run, 0);
                if (c == 14) begin chk("run_c14", run, 1); chk("stage_c14", stageCount, 1); chk("bank_c14", bankSel, 1); end
                if (c == 22) chk("run_c22", run, 1);
                if (c == 23) chk("run_c23", run, 0);
                if (c == 27) begin chk("stage_c27", stageCount, 2); chk("bank_c27", bankSel, 0); end
                if (c == 40) begin chk("stage_c40", stageCount, 3); chk("bank_c40", bankSel, 1); end
                if (c == 48) chk("run_c48", run, 1);
                if (c == 49) chk("run_c49", run, 0);
                if (c == 52) chk("done_c52", done, 0);
                if (c == 53) begin chk("done_c53", done, 1); chk("busy_c53", busy, 1); end
                if (c == 54) begin chk("done_c54", done, 0); chk("busy_c54", busy, 0); end
            end
            2: begin
                if (c == 21) begin chk("abort_run", run, 0); chk("abort_busy", busy, 0); end
                if (c == 26) begin chk("restart_run", run, 1); chk("restart_stage", stageCount, 0); chk("restart_bank", bankSel, 0); end
                if (c == 78) chk("restart_done", done, 1);
            end
            3: begin
                if (c == 17) begin chk("to_run17", run, 1); chk("to_err17", err, 0); end
                if (c == 18) begin chk("to_err18", err, 1); chk("to_busy18", busy, 0); chk("to_run18", run, 0); end
                if (c == 100) chk("to_err100", err, 1);
                if (c == 102) begin chk("to_errclr", err, 0); chk("to_rerun", run, 1); end
            end
            4: begin
                if (c == 53) chk("held_done53", done, 1);
                if (c == 54) chk("held_busy54", busy, 0);
                if (c == 55) begin chk("held_run55", run, 1); chk("held_stage55", stageCount, 0); end
            end
            5: begin
                if (c == 31) begin
                    chk("rst_run", run, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
                    chk("rst_err", err, 0); chk("rst_stage", stageCount, 0); chk("rst_bank", bankSel, 0);
                end
                if (c == 84) chk("rst_done84", done, 0);
                if (c == 85) chk("rst_done85", done, 1);
            end
            6: begin
                if (c == 13) chk("frc_run13", run, 0);
                if (c == 14) begin chk("frc_run14", run, 1); chk("frc_stage14", stageCount, 1); end
                if (c == 53) chk("frc_done53", done, 1);
            end
            7: if (c == 53) begin chk("finrst_done", done, 0); chk("finrst_busy", busy, 0); end
            8: begin
                if (c == 10) begin chk("abagd_busy", busy, 0); chk("abagd_run", run, 0); end
                if (c == 39) begin chk("abdrn_busy", busy, 0); chk("abdrn_stage", stageCount, 1); chk("abdrn_bank", bankSel, 1); end
            end
            default: ;
        endcase
    endtask

    task automatic scenario(input int id, input int n);
        cur_id = id;
        cur_c = -1;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        step();
        ag_stuck = id == 3;
        ag_force = id == 6;
        step();
        reset = 1'b0;
        cur_c = 0;
        chk("rst_busy0", busy, 0);
        chk("rst_run0", run, 0);
        chk("rst_stage0", stageCount, 0);
        chk("rst_err0", err, 0);
        for (int c = 0; c <= n; c++) begin
            cur_c = c;
            lit(id, c);
            case (id)
                2:       begin start = c == 0 || c == 25; abort = c == 20 || c == 25; end
                3:       start = c == 0 || c == 101;
                4:       start = 1'b1;
                5:       begin start = c == 0 || c == 32; reset = c == 30; end
                7:       begin start = c == 0; reset = c == 52; end
                8:       begin start = c == 0 || c == 12; abort = c == 9 || c == 38; end
                default: start = c == 0;
            endcase
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog scn %0d cycle %0d", cur_id, cur_c);
        $fatal(1);
    end

    initial begin
        scenario(1, 60);
        scenario(2, 82);
        scenario(3, 105);
        scenario(4, 70);
        scenario(5, 88);
        scenario(6, 58);
        scenario(7, 58);
        scenario(8, 45);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
